// File: rtl/bootrom_loader.sv
// Boot image loader: parses framed bytes from a host byte stream and issues 16-bit RAM writes.
// Frames are guarded by an 8-bit wrapping checksum and an inter-byte timeout; cpu_hold is released on the first good frame.
module bootrom_loader #(
  parameter int          ADDR      = 13,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 65535
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [7:0]      s_data,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [15:0]     mem_write,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            cpu_hold
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ALO, S_AHI, S_CLO, S_CHI, S_DLO, S_DHI, S_CHK, S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [ADDR-1:0] r_base;
  logic [15:0]     r_cnt;
  logic [15:0]     r_idx;
  logic [7:0]      r_dlo;
  logic [7:0]      r_sum;
  logic [TW-1:0]   r_tcnt;
  logic            r_we;
  logic [ADDR-1:0] r_maddr;
  logic [15:0]     r_mwrite;
  logic            r_done;
  logic            r_error;
  logic            r_hold;

  logic            w_xfer;
  logic [7:0]      w_sum_nxt;
  logic [15:0]     w_idx_nxt;
  logic [15:0]     w_cnt_nxt;
  logic [ADDR-1:0] w_waddr;
  logic            w_in_frame;
  logic            w_tmo;

  assign w_xfer     = s_valid & s_ready;
  assign w_sum_nxt  = r_sum + s_data;
  assign w_idx_nxt  = r_idx + 16'd1;
  assign w_cnt_nxt  = {s_data, r_cnt[7:0]};
  assign w_waddr    = r_base + r_idx[ADDR-1:0];
  assign w_in_frame = (r_state != S_IDLE) && (r_state != S_ERR);
  // A transfer in the threshold cycle wins over the timeout.
  assign w_tmo      = w_in_frame && !w_xfer && (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_tmo) begin
      w_next = S_ERR;
    end else begin
      case (r_state)
        S_IDLE: if (w_xfer && s_data == SYNC_BYTE) w_next = S_ALO;
        S_ALO:  if (w_xfer) w_next = S_AHI;
        S_AHI:  if (w_xfer) w_next = S_CLO;
        S_CLO:  if (w_xfer) w_next = S_CHI;
        S_CHI:  if (w_xfer) w_next = (w_cnt_nxt == 16'd0) ? S_CHK : S_DLO;
        S_DLO:  if (w_xfer) w_next = S_DHI;
        S_DHI:  if (w_xfer) w_next = (w_idx_nxt == r_cnt) ? S_CHK : S_DLO;
        S_CHK:  if (w_xfer) w_next = (w_sum_nxt == 8'd0) ? S_IDLE : S_ERR;
        S_ERR:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready = (r_state != S_ERR);
    busy    = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= '0;
    end else if (!w_in_frame || w_xfer) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base   <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_dlo    <= '0;
      r_sum    <= '0;
      r_we     <= 1'b0;
      r_maddr  <= '0;
      r_mwrite <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_hold   <= 1'b1;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (r_state == S_ERR) r_error <= 1'b1;
      if (w_xfer && r_state != S_IDLE) r_sum <= w_sum_nxt;
      if (w_xfer && !w_tmo) begin
        case (r_state)
          S_IDLE: if (s_data == SYNC_BYTE) begin
            r_error <= 1'b0;
            r_hold  <= 1'b1;
            r_sum   <= 8'd0;
            r_idx   <= 16'd0;
          end
          S_ALO: r_base[7:0] <= s_data;
          S_AHI: r_base[ADDR-1:8] <= s_data[ADDR-9:0];
          S_CLO: r_cnt[7:0] <= s_data;
          S_CHI: begin
            r_cnt[15:8] <= s_data;
            r_idx       <= 16'd0;
          end
          S_DLO: r_dlo <= s_data;
          // The strobe lands one cycle after the high byte; address and data then hold.
          S_DHI: begin
            r_we     <= 1'b1;
            r_maddr  <= w_waddr;
            r_mwrite <= {s_data, r_dlo};
            r_idx    <= w_idx_nxt;
          end
          S_CHK: if (w_sum_nxt == 8'd0) begin
            r_done <= 1'b1;
            r_hold <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_maddr;
  assign mem_write = r_mwrite;
  assign done      = r_done;
  assign error     = r_error;
  assign cpu_hold  = r_hold;

endmodule
